// File: rtl/spu_stall_sched_pkg.sv
// spu_stall_sched_pkg
//   Shared constants for the SPU stall/flush scheduler.
//   - Stage bit indices into the [0:12] hold/kill vectors (12 = PC ... 7 = WR).
//   - Stall encodings for each request source and the branch-redirect kill vector.
//   - Miss-tracking FSM state type.
package spu_stall_sched_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;

  // Stage positions inside a logic [0:12] vector (index 12 is the rightmost bit)
  localparam int STAGE_PC  = 12;
  localparam int STAGE_IF  = 11;
  localparam int STAGE_ID  = 10;
  localparam int STAGE_EX  = 9;
  localparam int STAGE_MEM = 8;
  localparam int STAGE_WR  = 7;

  localparam logic [0:12] STALL_NONE = 13'b0000000000000;
  localparam logic [0:12] STALL_EX   = 13'b0000000001111;  // PC, IF, ID, EX
  localparam logic [0:12] STALL_ID   = 13'b0000000000111;  // PC, IF, ID
  localparam logic [0:12] STALL_MISS = 13'b0000000000011;  // PC, IF
  localparam logic [0:12] STALL_DH   = 13'b0000000001000;  // EX only
  localparam logic [0:12] FLUSH_BR   = 13'b0000000000110;  // kill IF, ID

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_MISS_WAIT = 1'b1
  } miss_state_e;

endpackage

// File: rtl/spu_stall_sched_sat_counter.sv
// spu_stall_sched_sat_counter
//   Saturating up-counter for performance statistics.
//   Ports: clk, rst (async, active-high), clr (sync clear, beats inc),
//          inc (count enable), count [W-1:0] (holds at all-ones).
module spu_stall_sched_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !(&count_reg)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/spu_stall_sched.sv
// spu_stall_sched
//   Merges ID/EX/data-hazard/cache stall requests into the per-stage hold
//   vector, tracks an outstanding I-cache miss, produces branch-redirect
//   kills (deferred while ID is held) and counts stalled cycles.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     stallreq_fr_id/_ex/_dh   stall requests from ID, EX, hazard unit
//     cache_miss, cache_refill_done  miss start / refill complete pulses
//     branch_flush             redirect pulse from EX
//     perf_clr                 synchronous clear of stall_cycles
//     stall, flush [0:12]      hold / kill vectors (12 = PC ... 7 = WR)
//     miss_busy                waiting for refill
//     miss_err                 sticky miss timeout flag
//     stall_cycles [CNT_W]     saturating stalled-cycle count
module spu_stall_sched
  import spu_stall_sched_pkg::*;
#(
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_fr_id,
  input  logic             stallreq_fr_ex,
  input  logic             stallreq_dh,
  input  logic             cache_miss,
  input  logic             cache_refill_done,
  input  logic             branch_flush,
  input  logic             perf_clr,
  output logic [0:12]      stall,
  output logic [0:12]      flush,
  output logic             miss_busy,
  output logic             miss_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MC_W = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;

  miss_state_e   state_reg;
  logic [MC_W-1:0] miss_cnt_reg;
  logic          flush_pend_reg;
  logic          flush_pend_next;
  logic          miss_err_reg;
  logic          miss_act;
  logic          flush_fire;
  logic [0:12]   stall_raw;

  // The miss holds the front end already in the cache_miss cycle.
  assign miss_act = ((state_reg == ST_IDLE) && cache_miss) || (state_reg == ST_MISS_WAIT);

  always_comb begin
    stall_raw = STALL_NONE;
    if (stallreq_fr_ex) begin
      stall_raw = STALL_EX;
    end else if (stallreq_fr_id == STOP) begin
      stall_raw = STALL_ID;
    end else if (miss_act) begin
      stall_raw = STALL_MISS;
    end else if (stallreq_dh) begin
      stall_raw = STALL_DH;
    end
  end

  // A redirect cannot kill IF/ID while ID is frozen; it waits, and further
  // redirects while waiting collapse into the same single kill.
  assign flush_fire = (branch_flush || flush_pend_reg) && !stall_raw[STAGE_ID];

  always_comb begin
    flush_pend_next = 1'b0;
    if (stall_raw[STAGE_ID]) begin
      flush_pend_next = flush_pend_reg || branch_flush;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign stall     = (rst == RST_ENABLE) ? STALL_NONE : stall_raw;
  assign flush     = ((rst != RST_ENABLE) && flush_fire) ? FLUSH_BR : STALL_NONE;
  assign miss_busy = (state_reg == ST_MISS_WAIT);
  assign miss_err  = miss_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      miss_cnt_reg   <= '0;
      flush_pend_reg <= 1'b0;
      miss_err_reg   <= 1'b0;
    end else begin
      flush_pend_reg <= flush_pend_next;
      case (state_reg)
        ST_IDLE: begin
          // A simultaneous refill_done is meaningless here and is dropped.
          if (cache_miss) begin
            state_reg    <= ST_MISS_WAIT;
            miss_cnt_reg <= '0;
          end
        end
        ST_MISS_WAIT: begin
          miss_cnt_reg <= miss_cnt_reg + MC_W'(1);
          if (cache_refill_done) begin
            state_reg <= ST_IDLE;
          end else if (miss_cnt_reg == MC_W'(MISS_TIMEOUT - 1)) begin
            state_reg    <= ST_IDLE;
            miss_err_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  spu_stall_sched_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (|stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_spu_stall_sched.sv
module tb_spu_stall_sched;

  localparam int MT = 8;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [0:12] E_NONE = 13'b0000000000000;
  localparam logic [0:12] E_EX   = 13'b0000000001111;
  localparam logic [0:12] E_ID   = 13'b0000000000111;
  localparam logic [0:12] E_MS   = 13'b0000000000011;
  localparam logic [0:12] E_DH   = 13'b0000000001000;
  localparam logic [0:12] E_FB   = 13'b0000000000110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id = 0, ex = 0, dh = 0, miss = 0, done = 0, bf = 0, clr = 0;
  logic [0:12]   stall, flush;
  logic          miss_busy, miss_err;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  spu_stall_sched #(.MISS_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_fr_id    (id),
    .stallreq_fr_ex    (ex),
    .stallreq_dh       (dh),
    .cache_miss        (miss),
    .cache_refill_done (done),
    .branch_flush      (bf),
    .perf_clr          (clr),
    .stall             (stall),
    .flush             (flush),
    .miss_busy         (miss_busy),
    .miss_err          (miss_err),
    .stall_cycles      (stall_cycles)
  );

  typedef struct {
    int          cyc;
    logic [0:12] st;
    logic [0:12] fl;
    logic        busy;
    logic        err;
    logic        ck;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  // Stimulus: drive one cycle of inputs and queue what the DUT must show.
  task automatic cyc(input logic r, input logic i_id, input logic i_ex, input logic i_dh,
                     input logic i_miss, input logic i_done, input logic i_bf, input logic i_clr,
                     input logic [0:12] es, input logic [0:12] ef, input logic eb, input logic ee,
                     input logic ck, input int ec);
    exp_t e;
    @(posedge clk); #1;
    rst = r; id = i_id; ex = i_ex; dh = i_dh; miss = i_miss; done = i_done; bf = i_bf; clr = i_clr;
    e.cyc = cyc_no; e.st = es; e.fl = ef; e.busy = eb; e.err = ee; e.ck = ck; e.cnt = ec;
    exp_q.push_back(e);
    cyc_no++;
  endtask

  // Monitor: every falling edge, pop the pending expectation and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (stall !== e.st) begin
        n_fail++;
        $display("FAIL stall cyc=%0d got=%b want=%b", e.cyc, stall, e.st);
      end
      n_checks++;
      if (flush !== e.fl) begin
        n_fail++;
        $display("FAIL flush cyc=%0d got=%b want=%b", e.cyc, flush, e.fl);
      end
      n_checks++;
      if (miss_busy !== e.busy) begin
        n_fail++;
        $display("FAIL miss_busy cyc=%0d got=%b want=%b", e.cyc, miss_busy, e.busy);
      end
      n_checks++;
      if (miss_err !== e.err) begin
        n_fail++;
        $display("FAIL miss_err cyc=%0d got=%b want=%b", e.cyc, miss_err, e.err);
      end
      if (e.ck) begin
        n_checks++;
        if (stall_cycles !== CW'(e.cnt)) begin
          n_fail++;
          $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", e.cyc, stall_cycles, e.cnt);
        end
      end
      $display("cyc=%0d stall=%b flush=%b busy=%b err=%b cnt=%0d", e.cyc, stall, flush,
               miss_busy, miss_err, stall_cycles);
    end
  end

  initial begin
    //   rst id ex dh ms dn bf cl   stall   flush  busy err ck cnt
    // reset: outputs forced quiet even with requests present
    cyc(1, 1, 0, 0, 0, 0, 1, 0,  E_NONE, E_NONE, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0,  E_NONE, E_NONE, 0, 0, 1, 0);
    // priority
    cyc(0, 1, 1, 1, 0, 0, 0, 0,  E_EX,   E_NONE, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 0,  E_ID,   E_NONE, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0,  E_DH,   E_NONE, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1,  E_NONE, E_NONE, 0, 0, 1, 3);
    // miss, refill 5 cycles later; a redirect mid-miss kills at once
    cyc(0, 0, 0, 0, 1, 0, 0, 0,  E_MS,   E_NONE, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_MS,   E_NONE, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0,  E_MS,   E_FB,   1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_MS,   E_NONE, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0,  E_MS,   E_NONE, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0,  E_MS,   E_NONE, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 0, 1, 6);
    // timeout (miss+done together in IDLE still enters the wait)
    cyc(0, 0, 0, 0, 1, 1, 0, 0,  E_MS,   E_NONE, 0, 0, 0, 0);
    for (int i = 0; i < MT; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, E_MS,  E_NONE, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 1, 1, 15);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 1, 1, 15);
    // deferred flush with a merged second redirect
    cyc(0, 1, 0, 0, 0, 0, 1, 0,  E_ID,   E_NONE, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0,  E_ID,   E_NONE, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0,  E_ID,   E_NONE, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_FB,   0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 1, 0, 0);
    // redirect under a hazard bubble (ID not held) kills immediately
    cyc(0, 0, 0, 1, 0, 0, 1, 0,  E_DH,   E_FB,   0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 1, 1, 19);
    // reset mid-miss with a flush pending, then a fresh miss
    cyc(0, 0, 0, 0, 1, 0, 0, 0,  E_MS,   E_NONE, 0, 1, 1, 19);
    cyc(0, 1, 0, 0, 0, 0, 1, 0,  E_ID,   E_NONE, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0,  E_MS,   E_NONE, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0,  E_MS,   E_NONE, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 0, 1, 2);
    // saturation of the stall counter
    cyc(0, 0, 0, 0, 0, 0, 0, 1,  E_NONE, E_NONE, 0, 0, 1, 2);
    for (int i = 0; i < (1 << CW) + 3; i++)
      cyc(0, 0, 0, 1, 0, 0, 0, 0, E_DH,  E_NONE, 0, 0, 1, (i > CMAX) ? CMAX : i);
    cyc(0, 0, 0, 1, 0, 0, 0, 1,  E_DH,   E_NONE, 0, 0, 1, CMAX);
    cyc(0, 0, 0, 0, 0, 0, 0, 0,  E_NONE, E_NONE, 0, 0, 1, 0);

    // let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
